// File: rtl/quad_cmd_pkg.sv
// quad_cmd_pkg: shared types for the quad-side host command link.
//  cmd_t       - command byte encoding seen on the cmd output
//  asm_state_t - frame assembler states
//  rx_state_t  - byte receiver states
//  tx_state_t  - response transmitter states
//  POS_ACK     - positive acknowledge response byte
package quad_cmd_pkg;

  typedef enum logic [7:0] {
    SET_PITCH  = 8'h02,
    SET_ROLL   = 8'h03,
    SET_YAW    = 8'h04,
    SET_THRST  = 8'h05,
    CALIBRATE  = 8'h06,
    E_LAND     = 8'h07,
    MOTORS_OFF = 8'h08
  } cmd_t;

  typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO} asm_state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser for the 1-byte host response.
//  clk, rst  - clock, asynchronous active-high reset
//  trmt      - strobe: start sending tx_data (ignored while busy)
//  tx_data   - byte to send, captured on the accepted trmt cycle
//  TX        - serial line, idle high
//  tx_done   - level: last byte fully sent, held until next accepted trmt
//  busy      - high from the accept cycle until the stop bit ends
module uart_tx
  import quad_cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy
);

  localparam int unsigned CW = $clog2(BAUD_DIV);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  // TX is registered: the start bit is already on the line the cycle
  // after the accept edge, so shreg only holds the data bits and stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (trmt) begin
            shreg    <= {1'b1, tx_data};
            TX       <= 1'b0;
            busy     <= 1'b1;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (baud_cnt == CW'(BAUD_DIV - 1)) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              state   <= TX_IDLE;
              busy    <= 1'b0;
              tx_done <= 1'b1;
              TX      <= 1'b1;
            end else begin
              TX      <= shreg[0];
              shreg   <= {1'b1, shreg[8:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: quad-side end of the host command link.
// Receives 3-byte frames {cmd, data[15:8], data[7:0]} on RX and presents
// them as cmd/data with cmd_rdy; sends a 1-byte response on TX.
//  clk, rst     - clock, asynchronous active-high reset
//  RX / TX      - serial in / out, idle high
//  clr_cmd_rdy  - strobe: knock down cmd_rdy
//  cmd_rdy      - level: complete frame held in cmd/data
//  cmd, data    - command byte and 16-bit payload
//  send_resp    - strobe: send resp (ignored while tx_busy)
//  resp         - response byte
//  resp_sent    - level: last response fully sent
//  tx_busy      - transmitter busy
// Build option: define CMD_TIMEOUT_EN to drop a partial frame after
// TIMEOUT_CYC idle cycles between its bytes.
module uart_cmd_wrapper
  import quad_cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = 2604,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  localparam int unsigned CW = $clog2(BAUD_DIV);

  if (BAUD_DIV < 8) begin : g_bad_baud
    $error("BAUD_DIV must be >= 8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be >= 2");
  end

  // ---------------- receiver ----------------
  logic          rx_meta, rx_s;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          tick, byte_good, byte_bad;

  assign tick      = (rx_cnt == CW'(BAUD_DIV - 1));
  assign byte_good = (rx_state == RX_STOP) && tick && rx_s;
  assign byte_bad  = (rx_state == RX_STOP) && tick && !rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CW'(BAUD_DIV / 2 - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (tick) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- assembler ----------------
  asm_state_t asm_state;
  logic [7:0] cmd_sh, hi_sh, lo_sh;
  logic       frame_done;
  logic       timeout;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] to_cnt;

  assign timeout = (asm_state != WAIT_CMD) && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (asm_state == WAIT_CMD || byte_good || timeout)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // The third byte only fills a shadow; cmd/data/cmd_rdy are loaded
  // together on the following cycle so they never change while cmd_rdy=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_state  <= WAIT_CMD;
      cmd_sh     <= '0;
      hi_sh      <= '0;
      lo_sh      <= '0;
      frame_done <= 1'b0;
      cmd        <= '0;
      data       <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_done) begin
        cmd  <= cmd_sh;
        data <= {hi_sh, lo_sh};
      end
      if (frame_done)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy || (byte_good && asm_state == WAIT_CMD))
        cmd_rdy <= 1'b0;

      if (byte_bad) begin
        asm_state <= WAIT_CMD;
      end else if (byte_good) begin
        case (asm_state)
          WAIT_CMD: begin
            cmd_sh    <= rx_shift;
            asm_state <= WAIT_HI;
          end
          WAIT_HI: begin
            hi_sh     <= rx_shift;
            asm_state <= WAIT_LO;
          end
          WAIT_LO: begin
            lo_sh      <= rx_shift;
            frame_done <= 1'b1;
            asm_state  <= WAIT_CMD;
          end
          default: asm_state <= WAIT_CMD;
        endcase
      end else if (timeout) begin
        asm_state <= WAIT_CMD;
      end
    end
  end

  // ---------------- transmitter ----------------
  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (send_resp),
    .tx_data (resp),
    .TX      (TX),
    .tx_done (resp_sent),
    .busy    (tx_busy)
  );

endmodule
